// File: rtl/axi_aw_scheduler.sv
// Round-robin AW channel scheduler: N slave ports onto one master AW port, with ID push to the write-data allocator.
// Optional write-outstanding limit enabled by defining AXI_AW_OUTSTANDING_LIMIT_EN.
module axi_aw_scheduler #(
  parameter int N_TARG_PORT     = 7,
  parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W    = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_TARG_PORT-1:0]                  awvalid_i,
  input  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0] awpayload_i,
  output logic [N_TARG_PORT-1:0]                  awready_o,
  output logic                                    awvalid_o,
  output logic [AW_PAYLOAD_W-1:0]                 awpayload_o,
  input  logic                                    awready_i,
  output logic                                    push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]       ID_o,
  input  logic                                    grant_FIFO_ID_i,
  input  logic                                    bvalid_i,
  input  logic                                    bready_i
);

  localparam int IDX_W = (LOG_N_TARG > 0) ? LOG_N_TARG : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0] lock_idx_reg, lock_idx_next;
  logic [IDX_W-1:0] rr_sel, cur_sel, pos_idx;
  logic             rr_found;
  logic             limit_active;
  logic [N_TARG_PORT-1:0] id_onehot;
  int               pos_int;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (N_TARG_PORT == 1 || int'(idx) >= N_TARG_PORT - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Scan from lowest to highest priority so the last hit is the port closest to rr_ptr.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    pos_int  = 0;
    pos_idx  = '0;
    for (int k = N_TARG_PORT - 1; k >= 0; k--) begin
      pos_int = int'(rr_ptr_reg) + k;
      if (pos_int >= N_TARG_PORT) pos_int = pos_int - N_TARG_PORT;
      pos_idx = IDX_W'(pos_int);
      if (awvalid_i[pos_idx]) begin
        rr_found = 1'b1;
        rr_sel   = pos_idx;
      end
    end
  end

  assign cur_sel     = (state_reg == LOCKED) ? lock_idx_reg : rr_sel;
  assign awpayload_o = awpayload_i[cur_sel];

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    lock_idx_next = lock_idx_reg;
    awvalid_o     = 1'b0;
    awready_o     = '0;
    push_ID_o     = 1'b0;
    // Outputs are gated by rst_n so they drop as soon as reset asserts.
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          if (rr_found && grant_FIFO_ID_i && !limit_active) begin
            awvalid_o          = 1'b1;
            awready_o[cur_sel] = awready_i;
            if (awready_i) begin
              push_ID_o   = 1'b1;
              rr_ptr_next = wrap_inc(cur_sel);
            end else begin
              lock_idx_next = cur_sel;
              state_next    = LOCKED;
            end
          end
        end
        LOCKED: begin
          awvalid_o               = awvalid_i[lock_idx_reg];
          awready_o[lock_idx_reg] = awready_i;
          if (awvalid_i[lock_idx_reg] && awready_i) begin
            push_ID_o   = 1'b1;
            rr_ptr_next = wrap_inc(lock_idx_reg);
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      lock_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N_TARG_PORT; gi++) begin : g_onehot
      assign id_onehot[gi] = (cur_sel == IDX_W'(gi));
    end
    if (LOG_N_TARG > 0) begin : g_id_bin
      assign ID_o = {cur_sel, id_onehot};
    end else begin : g_id_nobin
      assign ID_o = id_onehot;
    end
  endgenerate

`ifdef AXI_AW_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] out_cnt_reg;
  logic             b_hs;

  assign b_hs         = bvalid_i & bready_i;
  assign limit_active = (out_cnt_reg == CNT_W'(MAX_OUTSTANDING));

  // Saturating in both directions; a LOCKED handshake at the limit must not wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_reg <= '0;
    end else begin
      case ({push_ID_o, b_hs})
        2'b10: if (out_cnt_reg != CNT_W'(MAX_OUTSTANDING)) out_cnt_reg <= out_cnt_reg + 1'b1;
        2'b01: if (out_cnt_reg != '0) out_cnt_reg <= out_cnt_reg - 1'b1;
        default: ;
      endcase
    end
  end
`else
  logic unused_b;

  assign limit_active = 1'b0;
  assign unused_b     = bvalid_i ^ bready_i ^ (MAX_OUTSTANDING == 0);
`endif

endmodule

// File: tb/tb_axi_aw_scheduler.sv
// Directed self-checking bench for axi_aw_scheduler (7 ports, MAX_OUTSTANDING=2).
module tb_axi_aw_scheduler;

  localparam int N = 7;
  localparam int L = 3;
  localparam int W = 64;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     awvalid_i;
  logic [N-1:0][W-1:0] awpayload_i;
  logic [N-1:0]     awready_o;
  logic             awvalid_o;
  logic [W-1:0]     awpayload_o;
  logic             awready_i;
  logic             push_ID_o;
  logic [L+N-1:0]   ID_o;
  logic             grant_FIFO_ID_i;
  logic             bvalid_i;
  logic             bready_i;

  int checks = 0;
  int fails  = 0;

  axi_aw_scheduler #(
    .N_TARG_PORT(N), .LOG_N_TARG(L), .AW_PAYLOAD_W(W), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid_i(awvalid_i), .awpayload_i(awpayload_i), .awready_o(awready_o),
    .awvalid_o(awvalid_o), .awpayload_o(awpayload_o), .awready_i(awready_i),
    .push_ID_o(push_ID_o), .ID_o(ID_o), .grant_FIFO_ID_i(grant_FIFO_ID_i),
    .bvalid_i(bvalid_i), .bready_i(bready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [L+N-1:0] id_of(input int p);
    logic [N-1:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    return {L'(p), oh};
  endfunction

  function automatic logic [W-1:0] pay_of(input int p);
    return {32'hC0DE_0000 + 32'(p), 32'h0000_1000 * 32'(p)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awvalid_i = '1; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1;
    #1;
    checks++;
    if (awvalid_o !== 1'b0) begin fails++; $display("FAIL reset_awvalid: got %b expected 0", awvalid_o); end
    checks++;
    if (awready_o !== 7'b0) begin fails++; $display("FAIL reset_awready: got %b expected 0000000", awready_o); end
    checks++;
    if (push_ID_o !== 1'b0) begin fails++; $display("FAIL reset_push: got %b expected 0", push_ID_o); end
    $display("reset: awvalid_o=%b awready_o=%b push_ID_o=%b", awvalid_o, awready_o, push_ID_o);
    awvalid_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alternate();
    int exp_p;
    awvalid_i = 7'b0000101; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_p = (i % 2 == 0) ? 0 : 2;
      #1;
      checks++;
      if (push_ID_o !== 1'b1) begin fails++; $display("FAIL alt_push[%0d]: got %b expected 1", i, push_ID_o); end
      checks++;
      if (ID_o !== id_of(exp_p)) begin fails++; $display("FAIL alt_id[%0d]: got %h expected %h", i, ID_o, id_of(exp_p)); end
      checks++;
      if (awready_o !== 7'(1 << exp_p)) begin fails++; $display("FAIL alt_awready[%0d]: got %b expected %b", i, awready_o, 7'(1 << exp_p)); end
      $display("alternate[%0d]: ID_o=%h push=%b", i, ID_o, push_ID_o);
      tick();
    end
  endtask

  task automatic test_lock();
    awvalid_i = 7'b0001000; awready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) awvalid_i[1] = 1'b1;
      #1;
      checks++;
      if (awvalid_o !== 1'b1 || awpayload_o !== pay_of(3)) begin
        fails++; $display("FAIL lock_hold[%0d]: got valid=%b payload=%h expected valid=1 payload=%h", i, awvalid_o, awpayload_o, pay_of(3));
      end
      checks++;
      if (push_ID_o !== 1'b0) begin fails++; $display("FAIL lock_nopush[%0d]: got %b expected 0", i, push_ID_o); end
      $display("lock wait[%0d]: payload=%h push=%b", i, awpayload_o, push_ID_o);
      tick();
    end
    awready_i = 1'b1;
    #1;
    checks++;
    if (push_ID_o !== 1'b1 || ID_o !== id_of(3)) begin
      fails++; $display("FAIL lock_release: got push=%b ID=%h expected push=1 ID=%h", push_ID_o, ID_o, id_of(3));
    end
    checks++;
    if (awready_o !== 7'b0001000) begin fails++; $display("FAIL lock_awready: got %b expected 0001000", awready_o); end
    $display("lock release: ID_o=%h push=%b", ID_o, push_ID_o);
    tick();
    awvalid_i = '1;
    #1;
    checks++;
    if (push_ID_o !== 1'b1 || ID_o !== id_of(4)) begin
      fails++; $display("FAIL lock_rr_next: got push=%b ID=%h expected push=1 ID=%h", push_ID_o, ID_o, id_of(4));
    end
    $display("after lock: ID_o=%h push=%b", ID_o, push_ID_o);
    tick();
  endtask

  task automatic test_wrap();
    int exp_tab [3] = '{5, 6, 0};
    awvalid_i = '1; awready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (push_ID_o !== 1'b1 || ID_o !== id_of(exp_tab[i])) begin
        fails++; $display("FAIL wrap[%0d]: got push=%b ID=%h expected push=1 ID=%h", i, push_ID_o, ID_o, id_of(exp_tab[i]));
      end
      $display("wrap[%0d]: ID_o=%h push=%b", i, ID_o, push_ID_o);
      tick();
    end
  endtask

  task automatic test_fifo_full();
    awvalid_i = '1; awready_i = 1'b1; grant_FIFO_ID_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (awvalid_o !== 1'b0 || awready_o !== 7'b0 || push_ID_o !== 1'b0) begin
        fails++; $display("FAIL fifo_block[%0d]: got valid=%b ready=%b push=%b expected all zero", i, awvalid_o, awready_o, push_ID_o);
      end
      $display("fifo full[%0d]: awvalid_o=%b push=%b", i, awvalid_o, push_ID_o);
      tick();
    end
    grant_FIFO_ID_i = 1'b1;
    #1;
    checks++;
    if (push_ID_o !== 1'b1 || ID_o !== id_of(1)) begin
      fails++; $display("FAIL fifo_resume: got push=%b ID=%h expected push=1 ID=%h", push_ID_o, ID_o, id_of(1));
    end
    $display("fifo resume: ID_o=%h push=%b", ID_o, push_ID_o);
    tick();
  endtask

  task automatic test_reset_in_locked();
    awvalid_i = 7'b0100000; awready_i = 1'b0;
    tick();
    awvalid_i = 7'b0110010;
    #1;
    checks++;
    if (awpayload_o !== pay_of(5) || awvalid_o !== 1'b1) begin
      fails++; $display("FAIL rstlock_locked: got valid=%b payload=%h expected valid=1 payload=%h", awvalid_o, awpayload_o, pay_of(5));
    end
    $display("locked before reset: payload=%h", awpayload_o);
    awready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (awvalid_o !== 1'b0 || awready_o !== 7'b0 || push_ID_o !== 1'b0) begin
      fails++; $display("FAIL rstlock_drop: got valid=%b ready=%b push=%b expected all zero", awvalid_o, awready_o, push_ID_o);
    end
    $display("reset in locked: awvalid_o=%b push=%b", awvalid_o, push_ID_o);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++;
    if (push_ID_o !== 1'b1 || ID_o !== id_of(1)) begin
      fails++; $display("FAIL rstlock_first: got push=%b ID=%h expected push=1 ID=%h", push_ID_o, ID_o, id_of(1));
    end
    $display("first after reset: ID_o=%h push=%b", ID_o, push_ID_o);
    tick();
  endtask

`ifdef AXI_AW_OUTSTANDING_LIMIT_EN
  task automatic test_outstanding_limit();
    logic bv_tab [9]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic push_tab [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; awvalid_i = '0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    awvalid_i = 7'b0000001; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bvalid_i = bv_tab[i]; bready_i = 1'b1;
      #1;
      checks++;
      if (push_ID_o !== push_tab[i]) begin
        fails++; $display("FAIL limit[%0d]: got push=%b expected %b", i, push_ID_o, push_tab[i]);
      end
      $display("limit[%0d]: bvalid=%b push=%b", i, bvalid_i, push_ID_o);
      tick();
    end
    bvalid_i = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    awvalid_i = '0; awready_i = 1'b0; grant_FIFO_ID_i = 1'b1;
    bvalid_i = 1'b1; bready_i = 1'b1;
    for (int p = 0; p < N; p++) awpayload_i[p] = pay_of(p);
    test_reset();
    test_alternate();
    test_lock();
    test_wrap();
    test_fifo_full();
    test_reset_in_locked();
`ifdef AXI_AW_OUTSTANDING_LIMIT_EN
    test_outstanding_limit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
